cache_controller: RTL and testbench
===================================

# cache_controller

Miss-handling state machine for the direct-mapped, write-back, write-allocate data cache. It sits between the CPU memory stage and the cache array, and issues refill and write-back transactions to fixed-latency main memory. Hits are served in the same cycle. Misses stall the CPU, optionally write back the dirty victim, refill one 32-bit word, then replay the access as a hit.

## Interface
Parameters:
- MEM_LATENCY, 4, cycles a memory read/write strobe is held; read data valid in last cycle (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_b  in  1  reset, asynchronous, active-low
- cpu_read  in  1  load request, held by CPU while cpu_stall=1
- cpu_write  in  1  store request, held while cpu_stall=1; priority over cpu_read
- cpu_is_word  in  1  1 = word store, 0 = byte store
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data (byte in [7:0])
- cpu_stall  out  1  CPU must hold request and freeze
- cache_hit  in  1  from array: valid & tag match at cache_addr
- cache_dirty  in  1  from array: dirty bit at cache_addr
- cache_rdata  in  32  packed line word {data_out[3..0]}
- cache_wb_addr  in  32  from array: memory_write_address (victim address)
- cache_addr  out  32  address driven to array
- cache_wdata  out  32  write data to array
- cache_is_word  out  1  word/byte select to array
- we_cache  out  1  array data/tag write enable
- set_valid  out  1  valid bit written to array every cycle
- set_dirty  out  1  dirty bit written to array every cycle
- mem_addr  out  32  main memory word address
- mem_wdata  out  32  write-back data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  32  memory read data

## Operation
- The array rewrites valid/dirty at cache_addr on every edge. The controller must drive preserving values in every cycle that is not an update.
- req = cpu_read | cpu_write. States: IDLE, WRITEBACK, REFILL.
- IDLE, no req:
  - cache_addr = last_addr register (reset 0).
  - set_valid = cache_hit; set_dirty = cache_hit & cache_dirty; we_cache = 0.
- IDLE, req & hit:
  - cache_addr = cpu_addr; cpu_stall = 0.
  - Read: set_valid = 1, set_dirty = cache_dirty.
  - Write: we_cache = 1, cache_is_word = cpu_is_word, cache_wdata = cpu_wdata, set_valid = 1, set_dirty = 1.
  - last_addr ← cpu_addr.
- IDLE, req & miss:
  - cpu_stall = 1; set_valid = 0; set_dirty = 0; we_cache = 0.
  - Capture miss_addr ← cpu_addr, wb_addr ← cache_wb_addr, wb_data ← cache_rdata, cnt ← 0.
  - Next state is WRITEBACK if cache_dirty, else REFILL.
  - The victim is invalidated at this edge; its data survives in wb_data.
- WRITEBACK:
  - mem_we = 1, mem_addr = wb_addr, mem_wdata = wb_data.
  - cache_addr = miss_addr; set_valid = 0; set_dirty = 0; cpu_stall = 1.
  - cnt increments; when cnt = MEM_LATENCY-1, cnt ← 0 and go to REFILL.
- REFILL:
  - mem_re = 1, mem_addr = {16'b0, miss_addr[15:2], 2'b0}; cache_addr = miss_addr; cpu_stall = 1.
  - cnt increments. Before the last cycle: set_valid = 0, set_dirty = 0.
  - Last cycle (cnt = MEM_LATENCY-1): we_cache = 1, cache_is_word = 1, cache_wdata = mem_rdata, set_valid = 1, set_dirty = 0. Go to IDLE.
- Replay: back in IDLE the held request now hits and completes. A store miss therefore merges into the refilled word in the replay cycle.
- The decision is latched in IDLE only; cache_hit is ignored in WRITEBACK/REFILL.
- cpu_read & cpu_write together are handled as a write.
- Request dropped while stalled is illegal; behaviour is undefined.
- Outputs not listed in a state are 0: mem_*, we_cache, cache_wdata, cache_is_word.
- cpu_stall = req & ~(state==IDLE & cache_hit), combinational.

## Timing
- Reset (rst_b=0, asynchronous):
  - state IDLE; cnt, last_addr, miss_addr, wb_addr, wb_data = 0.
  - mem_we = mem_re = 0 immediately.
  - cpu_stall and the cache outputs follow the IDLE equations.
- Hit: 0 stall cycles.
- Clean miss: 1 + MEM_LATENCY stall cycles, then the hit cycle.
- Dirty miss: 1 + 2·MEM_LATENCY stall cycles.
- Memory strobes are held constant for exactly MEM_LATENCY consecutive cycles. No gap between WRITEBACK and REFILL.
- cnt width is $clog2(MEM_LATENCY)+1. cnt never exceeds MEM_LATENCY-1.
- MEM_LATENCY=1: WRITEBACK and REFILL each last one cycle. The refill write occurs in the single REFILL cycle.
- Reset mid-WRITEBACK/REFILL:
  - The FSM returns to IDLE and the strobes drop.
  - The target line stays invalid (it was invalidated at the miss edge), so a replayed request misses again.

## Test plan
- Read miss, clean, MEM_LATENCY=4, read 0x10 after reset:
  - cpu_stall high 5 cycles; mem_re high 4 cycles with mem_addr=0x10.
  - Refill word written with set_valid=1; next cycle hit, stall low.
- Dirty-victim miss: write word 0xAABBCCDD to 0x10 (hit after fill), then read 0x2010:
  - mem_we 4 cycles, mem_addr=0x10, mem_wdata=0xAABBCCDD.
  - Then mem_re 4 cycles, mem_addr=0x2010; stall 9 cycles.
- Byte store hit to 0x13, data 0x5A:
  - Single cycle: we_cache=1, cache_is_word=0, cache_addr=0x13, set_dirty=1, cpu_stall=0.
- Word store miss to 0x40 (clean):
  - Refill writes mem_rdata; replay cycle writes cpu_wdata with set_dirty=1.
  - A subsequent read of 0x40 hits and returns cpu_wdata.
- rst_b low during REFILL cycle 2:
  - mem_re drops asynchronously; state IDLE.
  - The retried read misses and performs a full 4-cycle refill.
- Idle after hit on 0x10 for 10 cycles:
  - set_valid=1 and set_dirty equals the prior dirty bit every cycle; the line is not lost.

Source files
------------

// File: rtl/cache_controller_if.sv
// Signal bundle between the miss-handling controller, the CPU memory stage,
// the cache array and main memory. master = controller side.
interface cache_controller_if;
    logic        cpu_read;
    logic        cpu_write;
    logic        cpu_is_word;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;

    logic        cache_hit;
    logic        cache_dirty;
    logic [31:0] cache_rdata;
    logic [31:0] cache_wb_addr;
    logic [31:0] cache_addr;
    logic [31:0] cache_wdata;
    logic        cache_is_word;
    logic        we_cache;
    logic        set_valid;
    logic        set_dirty;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport master (
        input  cpu_read, cpu_write, cpu_is_word, cpu_addr, cpu_wdata,
        output cpu_stall,
        input  cache_hit, cache_dirty, cache_rdata, cache_wb_addr,
        output cache_addr, cache_wdata, cache_is_word, we_cache, set_valid, set_dirty,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport slave (
        output cpu_read, cpu_write, cpu_is_word, cpu_addr, cpu_wdata,
        input  cpu_stall,
        output cache_hit, cache_dirty, cache_rdata, cache_wb_addr,
        input  cache_addr, cache_wdata, cache_is_word, we_cache, set_valid, set_dirty,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/cache_controller.sv
// Miss handler for a direct-mapped write-back/write-allocate cache: serves hits
// combinationally, writes back a dirty victim, refills one word, then replays.
module cache_controller #(
    parameter int MEM_LATENCY = 4
) (
    input logic               clk,
    input logic               rst_b,
    cache_controller_if.master bus
);
    localparam int CW = $clog2(MEM_LATENCY) + 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   last_addr, last_nxt;
    logic [31:0]   miss_addr, wb_addr, wb_data;
    logic          capture;
    logic          req;

    assign req = bus.cpu_read | bus.cpu_write;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            cnt       <= '0;
            last_addr <= '0;
            miss_addr <= '0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last_addr <= last_nxt;
            if (capture) begin
                miss_addr <= bus.cpu_addr;
                wb_addr   <= bus.cache_wb_addr;
                wb_data   <= bus.cache_rdata;
            end
        end
    end

    // The array rewrites valid/dirty every edge, so every non-update cycle
    // must drive values that preserve the line currently addressed.
    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        last_nxt          = last_addr;
        capture           = 1'b0;
        bus.cpu_stall     = req & ~((state == IDLE) & bus.cache_hit);
        bus.cache_addr    = last_addr;
        bus.cache_wdata   = '0;
        bus.cache_is_word = 1'b0;
        bus.we_cache      = 1'b0;
        bus.set_valid     = 1'b0;
        bus.set_dirty     = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.mem_we        = 1'b0;
        bus.mem_re        = 1'b0;
        case (state)
            IDLE: begin
                if (!req) begin
                    bus.set_valid = bus.cache_hit;
                    bus.set_dirty = bus.cache_hit & bus.cache_dirty;
                end else begin
                    bus.cache_addr = bus.cpu_addr;
                    if (bus.cache_hit) begin
                        last_nxt      = bus.cpu_addr;
                        bus.set_valid = 1'b1;
                        if (bus.cpu_write) begin
                            bus.we_cache      = 1'b1;
                            bus.cache_is_word = bus.cpu_is_word;
                            bus.cache_wdata   = bus.cpu_wdata;
                            bus.set_dirty     = 1'b1;
                        end else begin
                            bus.set_dirty = bus.cache_dirty;
                        end
                    end else begin
                        // Victim is invalidated here; its data lives on in wb_data.
                        capture   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = bus.cache_dirty ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                bus.mem_we     = 1'b1;
                bus.mem_addr   = wb_addr;
                bus.mem_wdata  = wb_data;
                bus.cache_addr = miss_addr;
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = REFILL;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            REFILL: begin
                bus.mem_re     = 1'b1;
                bus.mem_addr   = {16'b0, miss_addr[15:2], 2'b0};
                bus.cache_addr = miss_addr;
                if (cnt == LAST) begin
                    bus.we_cache      = 1'b1;
                    bus.cache_is_word = 1'b1;
                    bus.cache_wdata   = bus.mem_rdata;
                    bus.set_valid     = 1'b1;
                    cnt_nxt           = '0;
                    state_nxt         = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: models the cache array and main memory around the
// controller, runs directed vectors, reset/idle sequences and random traffic.
module tb_cache_controller;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    cache_controller_if bus();
    cache_controller #(.MEM_LATENCY(L)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [13:0] w);
        return 32'hC0DE0000 | {16'b0, w, 2'b0};
    endfunction

    // ---------------- environment: cache array + main memory ----------------
    logic        av [0:63] = '{default: 1'b0};
    logic        ad [0:63] = '{default: 1'b0};
    logic [7:0]  at [0:63] = '{default: 8'h0};
    logic [31:0] adata [0:63] = '{default: 32'h0};
    logic [31:0] mem [0:16383] = '{default: 32'h0};
    logic        mw [0:16383] = '{default: 1'b0};
    logic [5:0]  aidx;
    logic [13:0] midx;

    assign aidx              = bus.cache_addr[7:2];
    assign midx              = bus.mem_addr[15:2];
    assign bus.cache_hit     = av[aidx] && (at[aidx] == bus.cache_addr[15:8]);
    assign bus.cache_dirty   = ad[aidx];
    assign bus.cache_rdata   = adata[aidx];
    assign bus.cache_wb_addr = {16'b0, at[aidx], aidx, 2'b0};
    assign bus.mem_rdata     = mw[midx] ? mem[midx] : init_word(midx);

    always @(posedge clk) begin
        av[aidx] <= bus.set_valid;
        ad[aidx] <= bus.set_dirty;
        if (bus.we_cache) begin
            at[aidx] <= bus.cache_addr[15:8];
            if (bus.cache_is_word) adata[aidx] <= bus.cache_wdata;
            else adata[aidx][8*bus.cache_addr[1:0] +: 8] <= bus.cache_wdata[7:0];
        end
        if (bus.mem_we) begin
            mem[midx] <= bus.mem_wdata;
            mw[midx]  <= 1'b1;
        end
    end

    // ---------------- reference model: CPU-visible memory + line tags ----------------
    bit          mv [0:63];
    bit          md [0:63];
    logic [7:0]  mt [0:63];
    logic [31:0] gmem [int];

    function automatic logic [31:0] gval(input logic [13:0] w);
        return gmem.exists(int'(w)) ? gmem[int'(w)] : init_word(w);
    endfunction

    typedef struct {
        int          stalls, we_cyc, re_cyc;
        logic [31:0] wb_addr, wb_data, re_addr, rdata, hit_addr, hit_wdata;
        bit          strobe_ok, timeout, hit_we, hit_isw, hit_valid, hit_dirty;
    } res_t;

    typedef struct {
        bit          rd, wr, isw;
        logic [31:0] addr, wdata;
        int          es, ewe, ere;
        logic [31:0] erd, ewba, ewbd, erea;
    } vec_t;

    function automatic vec_t mkv(bit rd, bit wr, bit isw, logic [31:0] addr, logic [31:0] wdata,
                                 int es, int ewe, int ere, logic [31:0] erd,
                                 logic [31:0] ewba, logic [31:0] ewbd, logic [31:0] erea);
        vec_t v;
        v.rd = rd; v.wr = wr; v.isw = isw; v.addr = addr; v.wdata = wdata;
        v.es = es; v.ewe = ewe; v.ere = ere; v.erd = erd;
        v.ewba = ewba; v.ewbd = ewbd; v.erea = erea;
        return v;
    endfunction

    // Predicts one access from cache-policy rules, then commits it to the model.
    task automatic model_access(input bit wr, input bit isw, input logic [31:0] addr,
                                input logic [31:0] wdata, output vec_t e);
        logic [5:0]  idx = addr[7:2];
        logic [7:0]  tag = addr[15:8];
        logic [13:0] w   = addr[15:2];
        logic [13:0] vw;
        logic [31:0] t;
        bit          hit = mv[idx] && (mt[idx] == tag);
        e = mkv(!wr, wr, isw, addr, wdata, 0, 0, 0, gval(w), 0, 0, 0);
        if (!hit) begin
            e.ere  = L;
            e.erea = {16'b0, w, 2'b0};
            if (md[idx]) begin
                vw     = {mt[idx], idx};
                e.ewe  = L;
                e.ewba = {16'b0, vw, 2'b0};
                e.ewbd = gval(vw);
                e.es   = 1 + 2 * L;
            end else begin
                e.es = 1 + L;
            end
        end
        if (wr) begin
            t = gval(w);
            if (isw) t = wdata;
            else t[8*addr[1:0] +: 8] = wdata[7:0];
            gmem[int'(w)] = t;
            md[idx] = 1'b1;
        end else begin
            md[idx] = hit ? md[idx] : 1'b0;
        end
        mv[idx] = 1'b1;
        mt[idx] = tag;
    endtask

    // Drives one request (entered at posedge+1) until its hit cycle completes.
    task automatic do_access(input bit rd, input bit wr, input bit isw, input logic [31:0] addr,
                             input logic [31:0] wdata, output res_t r);
        bit done = 1'b0;
        r = '{default: 0};
        r.strobe_ok = 1'b1;
        bus.cpu_read = rd; bus.cpu_write = wr; bus.cpu_is_word = isw;
        bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                if (r.we_cyc == 0) begin r.wb_addr = bus.mem_addr; r.wb_data = bus.mem_wdata; end
                else if (bus.mem_addr !== r.wb_addr || bus.mem_wdata !== r.wb_data) r.strobe_ok = 1'b0;
                r.we_cyc++;
            end
            if (bus.mem_re) begin
                if (r.re_cyc == 0) r.re_addr = bus.mem_addr;
                else if (bus.mem_addr !== r.re_addr) r.strobe_ok = 1'b0;
                if (r.we_cyc > 0 && !bus.mem_we && r.re_cyc == 0 && r.we_cyc != L) r.strobe_ok = 1'b0;
                r.re_cyc++;
            end
            if (!bus.cpu_stall) begin
                done        = 1'b1;
                r.rdata     = bus.cache_rdata;
                r.hit_addr  = bus.cache_addr;
                r.hit_wdata = bus.cache_wdata;
                r.hit_we    = bus.we_cache;
                r.hit_isw   = bus.cache_is_word;
                r.hit_valid = bus.set_valid;
                r.hit_dirty = bus.set_dirty;
            end else begin
                r.stalls++;
            end
            @(posedge clk); #1;
        end
        r.timeout = !done;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    endtask

    task automatic compare(input string n, input vec_t e, input res_t r);
        chk({n, "_timeout"}, 32'(r.timeout), 32'd0);
        chk({n, "_stall"}, r.stalls, e.es);
        chk({n, "_we_cycles"}, r.we_cyc, e.ewe);
        chk({n, "_re_cycles"}, r.re_cyc, e.ere);
        chk({n, "_strobe_steady"}, 32'(r.strobe_ok), 32'd1);
        if (e.ewe != 0) begin
            chk({n, "_wb_addr"}, r.wb_addr, e.ewba);
            chk({n, "_wb_data"}, r.wb_data, e.ewbd);
        end
        if (e.ere != 0) chk({n, "_re_addr"}, r.re_addr, e.erea);
        chk({n, "_hit_addr"}, r.hit_addr, e.addr);
        chk({n, "_hit_valid"}, 32'(r.hit_valid), 32'd1);
        if (e.wr) begin
            chk({n, "_hit_we"}, 32'(r.hit_we), 32'd1);
            chk({n, "_hit_isw"}, 32'(r.hit_isw), 32'(e.isw));
            chk({n, "_hit_dirty"}, 32'(r.hit_dirty), 32'd1);
            chk({n, "_hit_wdata"}, r.hit_wdata, e.wdata);
        end else begin
            chk({n, "_hit_we"}, 32'(r.hit_we), 32'd0);
            chk({n, "_rdata"}, r.rdata, e.erd);
        end
    endtask

    initial begin
        vec_t vecs [10];
        vec_t e;
        res_t r;
        int   re_seen;
        bit   rd, wr, isw;
        logic [31:0] a, d;

        vecs[0] = mkv(1, 0, 1, 32'h10,   0,            5, 0, 4, 32'hC0DE0010, 0,     0,            32'h10);
        vecs[1] = mkv(0, 1, 1, 32'h10,   32'hAABBCCDD, 0, 0, 0, 0,            0,     0,            0);
        vecs[2] = mkv(1, 0, 1, 32'h2010, 0,            9, 4, 4, 32'hC0DE2010, 32'h10, 32'hAABBCCDD, 32'h2010);
        vecs[3] = mkv(1, 0, 1, 32'h10,   0,            5, 0, 4, 32'hAABBCCDD, 0,     0,            32'h10);
        vecs[4] = mkv(0, 1, 0, 32'h13,   32'h5A,       0, 0, 0, 0,            0,     0,            0);
        vecs[5] = mkv(1, 0, 1, 32'h10,   0,            0, 0, 0, 32'h5ABBCCDD, 0,     0,            0);
        vecs[6] = mkv(0, 1, 1, 32'h40,   32'h12345678, 5, 0, 4, 0,            0,     0,            32'h40);
        vecs[7] = mkv(1, 0, 1, 32'h40,   0,            0, 0, 0, 32'h12345678, 0,     0,            0);
        vecs[8] = mkv(1, 1, 1, 32'h44,   32'hCAFEF00D, 5, 0, 4, 0,            0,     0,            32'h44);
        vecs[9] = mkv(1, 0, 1, 32'h44,   0,            0, 0, 0, 32'hCAFEF00D, 0,     0,            0);

        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_is_word = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_cache_addr", bus.cache_addr, 32'h0);
        chk("rst_set_valid", 32'(bus.set_valid), 32'd0);
        rst_b = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            model_access(vecs[i].wr, vecs[i].isw, vecs[i].addr, vecs[i].wdata, e);
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].isw, vecs[i].addr, vecs[i].wdata, r);
            compare($sformatf("v%0d", i), vecs[i], r);
        end

        // Idle after a hit on a dirty line: array contents must be preserved.
        model_access(0, 1, 32'h10, 0, e);
        do_access(1, 0, 1, 32'h10, 0, r);
        chk("idle_pre_stall", r.stalls, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_valid", c), 32'(bus.set_valid), 32'd1);
            chk($sformatf("idle%0d_dirty", c), 32'(bus.set_dirty), 32'd1);
            chk($sformatf("idle%0d_addr", c), bus.cache_addr, 32'h10);
        end
        @(posedge clk); #1;
        model_access(0, 1, 32'h10, 0, e);
        do_access(1, 0, 1, 32'h10, 0, r);
        chk("idle_post_stall", r.stalls, 0);
        chk("idle_post_rdata", r.rdata, 32'h5ABBCCDD);

        // Reset during the second refill cycle of a dirty miss.
        bus.cpu_read = 1'b1; bus.cpu_write = 1'b0; bus.cpu_is_word = 1'b1; bus.cpu_addr = 32'h2010;
        re_seen = 0;
        for (int c = 0; c < 64 && re_seen < 2; c++) begin
            @(negedge clk);
            if (bus.mem_re) re_seen++;
            if (re_seen < 2) begin @(posedge clk); #1; end
        end
        chk("rstmid_reached", re_seen, 2);
        rst_b = 1'b0;
        #1;
        chk("rstmid_mem_re", 32'(bus.mem_re), 32'd0);
        chk("rstmid_mem_we", 32'(bus.mem_we), 32'd0);
        bus.cpu_read = 1'b0;
        @(negedge clk);
        chk("rstmid_idle_stall", 32'(bus.cpu_stall), 32'd0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        mv[6'h04] = 1'b0;
        model_access(0, 1, 32'h2010, 0, e);
        do_access(1, 0, 1, 32'h2010, 0, r);
        compare("retry", mkv(1, 0, 1, 32'h2010, 0, 5, 0, 4, 32'hC0DE2010, 0, 0, 32'h2010), r);
        model_access(0, 1, 32'h10, 0, e);
        do_access(1, 0, 1, 32'h10, 0, r);
        compare("refetch", mkv(1, 0, 1, 32'h10, 0, 5, 0, 4, 32'h5ABBCCDD, 0, 0, 32'h10), r);

        // Random traffic against the model; few tags per index to force conflicts.
        for (int i = 0; i < 300; i++) begin
            a   = {16'b0, 8'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            d   = $urandom;
            wr  = $urandom_range(0, 1) == 1;
            rd  = !wr || ($urandom_range(0, 3) == 0);
            isw = $urandom_range(0, 1) == 1;
            model_access(wr, isw, a, d, e);
            e.rd = rd;
            do_access(rd, wr, isw, a, d, r);
            compare($sformatf("rnd%0d", i), e, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
